mult2_reward_eval: RTL

Sequential evaluation harness for 2-bit × 2-bit candidate multipliers, placed directly upstream and downstream of one candidate multiplier instance. It drives the candidate's A/B inputs through all 16 operand pairs and samples the candidate's 4-bit product. Each sample is compared with the exact product, and error statistics are accumulated. The RL training loop reads these statistics as the reward for the candidate.

---
 rtl/mult2_reward_eval.sv | 93 +++++++++
 1 files changed

// File: rtl/mult2_reward_eval.sv
// mult2_reward_eval: sweeps all 2x2-bit operand pairs through a candidate multiplier and accumulates error statistics.
module mult2_reward_eval #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  output logic [1:0] cand_a_o,
  output logic [1:0] cand_b_o,
  input  logic [3:0] cand_p_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       result_valid_o,
  output logic [4:0] err_count_o,
  output logic [7:0] err_sum_o,
  output logic [3:0] first_err_vec_o,
  output logic       first_err_valid_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state_q;
  logic [3:0] vec_q, cnt_q, fev_q, exact, abs_err;
  logic [4:0] ec_q, diff, abs5;
  logic [7:0] es_q;
  logic       busy_q, done_q, rv_q, fevld_q, sample, mismatch;
  assign exact    = {2'b0, vec_q[3:2]} * {2'b0, vec_q[1:0]};
  assign diff     = {1'b0, cand_p_i} - {1'b0, exact};
  assign abs5     = diff[4] ? -diff : diff;
  assign abs_err  = abs5[3:0];
  assign mismatch = cand_p_i != exact;
  assign sample   = cnt_q == 4'(SETTLE - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      ec_q    <= '0;
      es_q    <= '0;
      fev_q   <= '0;
      fevld_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          vec_q   <= '0;
          cnt_q   <= '0;
          rv_q    <= 1'b0;
          ec_q    <= '0;
          es_q    <= '0;
          fev_q   <= '0;
          fevld_q <= 1'b0;
        end
        RUN: if (abort_i) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (sample) begin
          if (mismatch) begin
            ec_q <= ec_q + 5'd1;
            es_q <= es_q + {4'b0, abs_err};
            if (!fevld_q) begin
              fev_q   <= vec_q;
              fevld_q <= 1'b1;
            end
          end
          if (vec_q == 4'hf) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rv_q    <= 1'b1;
          end else begin
            vec_q <= vec_q + 4'd1;
            cnt_q <= '0;
          end
        end else cnt_q <= cnt_q + 4'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cand_a_o          = vec_q[3:2];
  assign cand_b_o          = vec_q[1:0];
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign result_valid_o    = rv_q;
  assign err_count_o       = ec_q;
  assign err_sum_o         = es_q;
  assign first_err_vec_o   = fev_q;
  assign first_err_valid_o = fevld_q;
endmodule
